// File: rtl/adder_result_collector.sv
// ---------------------------------------------------------------------------
// adder_result_collector
//
// Sits behind the registered 4-bit adder stage. The adder's 5-bit sum shows
// up one cycle after its operand strobe, so the strobe is delayed by one
// cycle to line the two up again. Aligned sums are buffered in a small
// show-ahead FIFO drained through a valid/ready port, and every sum that
// enters the FIFO is also added into a saturating running total.
//
// Ports:
//   aclk      clock, rising edge
//   arst      synchronous active-high reset
//   op_valid  operands presented to the adder this cycle
//   y         adder registered sum (belongs to last cycle's op_valid)
//   clr       synchronous clear of acc / acc_ovf / drop_cnt (FIFO untouched)
//   m_valid   FIFO head valid
//   m_ready   consumer accepts head
//   m_data    FIFO head sum (show-ahead)
//   count     number of entries held
//   full      count == DEPTH
//   empty     count == 0
//   acc       saturating sum of accepted samples
//   acc_ovf   sticky flag, set when acc saturates
//   drop      combinational pulse: presented sample lost because FIFO full
//   drop_cnt  saturating count of dropped samples
// ---------------------------------------------------------------------------
module adder_result_collector #(
   parameter int DEPTH = 4,
   parameter int ACC_W = 12
) (
   input  logic                     aclk,
   input  logic                     arst,
   input  logic                     op_valid,
   input  logic [4:0]               y,
   input  logic                     clr,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [4:0]               m_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty,
   output logic [ACC_W-1:0]         acc,
   output logic                     acc_ovf,
   output logic                     drop,
   output logic [7:0]               drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
   localparam logic [ACC_W-1:0] ACC_MAX = '1;

   logic             vld_d1;
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [4:0]       mem [DEPTH];

   logic             presented;
   logic             push;
   logic             pop;
   logic [ACC_W:0]   acc_sum;
   logic             acc_sat;

   // Status is derived from the occupancy counter rather than from pointer
   // comparison, so full and empty never need an extra wrap bit.
   assign empty   = (count == '0);
   assign full    = (count == DEPTH_C);
   assign m_valid = !empty;
   assign m_data  = mem[rd_ptr];

   // A full FIFO can still accept a sample when the head leaves in the same
   // cycle; only a presented sample with no room and no pop is lost.
   always_comb begin
      presented = vld_d1;
      pop       = m_valid && m_ready;
      push      = presented && (!full || pop);
      drop      = presented && full && !pop;
   end

   // One extra bit on the running sum exposes the carry out of ACC_W bits,
   // which is exactly the saturation condition.
   always_comb begin
      acc_sum = {1'b0, acc} + {{(ACC_W-4){1'b0}}, y};
      acc_sat = acc_sum[ACC_W];
   end

   // Operand strobe delayed one cycle to match the adder's registered sum.
   // Clearing it in reset keeps the adder's post-reset zero out of the FIFO.
   always_ff @(posedge aclk) begin
      if (arst) begin
         vld_d1 <= 1'b0;
      end else begin
         vld_d1 <= op_valid;
      end
   end

   // Storage array; contents are only meaningful below count, so it is not
   // reset.
   always_ff @(posedge aclk) begin
      if (push) begin
         mem[wr_ptr] <= y;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two; the counter
   // moves only when exactly one of push/pop happens.
   always_ff @(posedge aclk) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Running total of pushed samples. clr takes priority over a coincident
   // push: the total restarts at zero and that sample is not counted.
   always_ff @(posedge aclk) begin
      if (arst) begin
         acc     <= '0;
         acc_ovf <= 1'b0;
      end else if (clr) begin
         acc     <= '0;
         acc_ovf <= 1'b0;
      end else if (push) begin
         if (acc_sat) begin
            acc     <= ACC_MAX;
            acc_ovf <= 1'b1;
         end else begin
            acc     <= acc_sum[ACC_W-1:0];
         end
      end
   end

   // Saturating drop counter, cleared together with the running total.
   always_ff @(posedge aclk) begin
      if (arst) begin
         drop_cnt <= '0;
      end else if (clr) begin
         drop_cnt <= '0;
      end else if (drop && (drop_cnt != 8'hFF)) begin
         drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_adder_result_collector.sv
// ---------------------------------------------------------------------------
// tb_adder_result_collector
//
// Directed bench for adder_result_collector. A small registered adder model
// feeds y one cycle after op_valid, as the real upstream stage does. A second
// instance with ACC_W = 6 shares all inputs so accumulator saturation can be
// reached with a handful of pushes. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled after a further settle delay.
// ---------------------------------------------------------------------------
module tb_adder_result_collector;

   logic       aclk;
   logic       arst;
   logic       op_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic [4:0] y;
   logic       clr;
   logic       m_ready;

   logic        m_valid;
   logic [4:0]  m_data;
   logic [2:0]  count;
   logic        full;
   logic        empty;
   logic [11:0] acc;
   logic        acc_ovf;
   logic        drop;
   logic [7:0]  drop_cnt;

   logic        m_valid6;
   logic [4:0]  m_data6;
   logic [2:0]  count6;
   logic        full6;
   logic        empty6;
   logic [5:0]  acc6;
   logic        ovf6;
   logic        drop6;
   logic [7:0]  drop_cnt6;

   int checks = 0;
   int errors = 0;

   adder_result_collector #(.DEPTH(4), .ACC_W(12)) dut (
      .aclk(aclk), .arst(arst), .op_valid(op_valid), .y(y), .clr(clr),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .count(count),
      .full(full), .empty(empty), .acc(acc), .acc_ovf(acc_ovf),
      .drop(drop), .drop_cnt(drop_cnt)
   );

   adder_result_collector #(.DEPTH(4), .ACC_W(6)) dut6 (
      .aclk(aclk), .arst(arst), .op_valid(op_valid), .y(y), .clr(clr),
      .m_valid(m_valid6), .m_ready(m_ready), .m_data(m_data6), .count(count6),
      .full(full6), .empty(empty6), .acc(acc6), .acc_ovf(ovf6),
      .drop(drop6), .drop_cnt(drop_cnt6)
   );

   // Clock generation
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // Upstream registered adder model
   always @(posedge aclk) begin
      if (arst) y <= 5'd0;
      else      y <= {1'b0, a} + {1'b0, b};
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic applyStimulus(input logic v, input logic [3:0] av, input logic [3:0] bv);
      op_valid = v;
      a = av;
      b = bv;
   endtask

   task automatic do_clr();
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b0;
      applyStimulus(1'b0, 4'd0, 4'd0);
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty got %0b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full got %0b want 0", full); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_m_valid got %0b want 0", m_valid); end
      checks++; if (acc !== 12'd0) begin errors++; $display("[TB] FAIL reset_acc got %0d want 0", acc); end
      checks++; if (acc_ovf !== 1'b0) begin errors++; $display("[TB] FAIL reset_acc_ovf got %0b want 0", acc_ovf); end
      checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL reset_drop got %0b want 0", drop); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
      checks++; if ({m_valid6, count6, full6, empty6, acc6, ovf6, drop6, drop_cnt6} !== {1'b0, 3'd0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b0, 8'd0})
         begin errors++; $display("[TB] FAIL reset_dut6 got cnt %0d empty %0b acc %0d", count6, empty6, acc6); end
      tick();
   endtask

   task automatic test_single_op();
      m_ready = 1'b1;
      applyStimulus(1'b1, 4'd3, 4'd5);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0);
      #1;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_early_valid got %0b want 0", m_valid); end
      tick();
      checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0b want 1", m_valid); end
      checks++; if (m_data !== 5'd8) begin errors++; $display("[TB] FAIL single_data got %0d want 8", m_data); end
      checks++; if (acc !== 12'd8) begin errors++; $display("[TB] FAIL single_acc got %0d want 8", acc); end
      tick();
      checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL single_count got %0d want 0", count); end
      m_ready = 1'b0;
   endtask

   task automatic test_burst();
      logic [3:0] av [4] = '{4'd1, 4'd2, 4'd7, 4'd15};
      logic [3:0] bv [4] = '{4'd1, 4'd2, 4'd8, 4'd15};
      logic [4:0] exp_d [4] = '{5'd2, 5'd4, 5'd15, 5'd30};
      do_clr();
      checks++; if (acc !== 12'd0) begin errors++; $display("[TB] FAIL burst_clr_acc got %0d want 0", acc); end
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, av[i], bv[i]);
         tick();
      end
      applyStimulus(1'b0, 4'd0, 4'd0);
      tick();
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL burst_full got %0b want 1", full); end
      checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL burst_count got %0d want 4", count); end
      checks++; if (acc !== 12'd51) begin errors++; $display("[TB] FAIL burst_acc got %0d want 51", acc); end
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (m_data !== exp_d[i]) begin errors++; $display("[TB] FAIL burst_drain_%0d got %0d want %0d", i, m_data, exp_d[i]); end
         tick();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL burst_empty got %0b want 1", empty); end
      m_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_clr();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'(i + 1), 4'd0);
         tick();
      end
      applyStimulus(1'b1, 4'd9, 4'd9);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0);
      #1;
      checks++; if (drop !== 1'b1) begin errors++; $display("[TB] FAIL ovf_drop got %0b want 1", drop); end
      checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL ovf_full got %0b want 1", full); end
      tick();
      checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drop_pulse got %0b want 0", drop); end
      checks++; if (drop_cnt !== 8'd1) begin errors++; $display("[TB] FAIL ovf_drop_cnt got %0d want 1", drop_cnt); end
      checks++; if (acc !== 12'd10) begin errors++; $display("[TB] FAIL ovf_acc got %0d want 10", acc); end
      checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL ovf_count got %0d want 4", count); end
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (m_data !== 5'(i + 1)) begin errors++; $display("[TB] FAIL ovf_drain_%0d got %0d want %0d", i, m_data, i + 1); end
         tick();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL ovf_empty got %0b want 1", empty); end
      m_ready = 1'b0;
   endtask

   task automatic test_full_pop_push();
      logic [4:0] exp_d [4] = '{5'd2, 5'd3, 5'd4, 5'd6};
      do_clr();
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'(i + 1), 4'd0);
         tick();
      end
      applyStimulus(1'b1, 4'd3, 4'd3);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0);
      m_ready = 1'b1;
      #1;
      checks++; if (drop !== 1'b0) begin errors++; $display("[TB] FAIL fpp_drop got %0b want 0", drop); end
      checks++; if (m_data !== 5'd1) begin errors++; $display("[TB] FAIL fpp_head got %0d want 1", m_data); end
      tick();
      checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL fpp_count got %0d want 4", count); end
      checks++; if (drop_cnt !== 8'd0) begin errors++; $display("[TB] FAIL fpp_drop_cnt got %0d want 0", drop_cnt); end
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (m_data !== exp_d[i]) begin errors++; $display("[TB] FAIL fpp_drain_%0d got %0d want %0d", i, m_data, exp_d[i]); end
         tick();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL fpp_empty got %0b want 1", empty); end
      checks++; if (acc !== 12'd16) begin errors++; $display("[TB] FAIL fpp_acc got %0d want 16", acc); end
      m_ready = 1'b0;
   endtask

   task automatic test_saturation_clr();
      logic [4:0] exp_d [4] = '{5'd30, 5'd30, 5'd30, 5'd5};
      do_clr();
      m_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'd15, 4'd15);
         tick();
      end
      applyStimulus(1'b0, 4'd0, 4'd0);
      #1;
      checks++; if (acc6 !== 6'd60) begin errors++; $display("[TB] FAIL sat_acc_pre got %0d want 60", acc6); end
      checks++; if (ovf6 !== 1'b0) begin errors++; $display("[TB] FAIL sat_ovf_pre got %0b want 0", ovf6); end
      tick();
      checks++; if (acc6 !== 6'd63) begin errors++; $display("[TB] FAIL sat_acc got %0d want 63", acc6); end
      checks++; if (ovf6 !== 1'b1) begin errors++; $display("[TB] FAIL sat_ovf got %0b want 1", ovf6); end
      checks++; if (acc !== 12'd90) begin errors++; $display("[TB] FAIL sat_wide_acc got %0d want 90", acc); end
      checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL sat_count got %0d want 3", count); end
      // clr lands in the same cycle the 2+3 sample is presented
      applyStimulus(1'b1, 4'd2, 4'd3);
      tick();
      applyStimulus(1'b0, 4'd0, 4'd0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++; if (acc6 !== 6'd0) begin errors++; $display("[TB] FAIL clr_acc6 got %0d want 0", acc6); end
      checks++; if (ovf6 !== 1'b0) begin errors++; $display("[TB] FAIL clr_ovf6 got %0b want 0", ovf6); end
      checks++; if (acc !== 12'd0) begin errors++; $display("[TB] FAIL clr_acc got %0d want 0", acc); end
      checks++; if (count !== 3'd4) begin errors++; $display("[TB] FAIL clr_count got %0d want 4", count); end
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (m_data !== exp_d[i]) begin errors++; $display("[TB] FAIL clr_drain_%0d got %0d want %0d", i, m_data, exp_d[i]); end
         checks++; if (m_data6 !== exp_d[i]) begin errors++; $display("[TB] FAIL clr_drain6_%0d got %0d want %0d", i, m_data6, exp_d[i]); end
         tick();
      end
      checks++; if (empty6 !== 1'b1) begin errors++; $display("[TB] FAIL clr_empty6 got %0b want 1", empty6); end
      m_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_clr();
      m_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i < 5) applyStimulus(1'b1, 4'(i + 1), 4'd0);
         else       applyStimulus(1'b0, 4'd0, 4'd0);
         #1;
         if (i >= 2) begin
            checks++; if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid_%0d got %0b want 1", i, m_valid); end
            checks++; if (m_data !== 5'(i - 1)) begin errors++; $display("[TB] FAIL b2b_data_%0d got %0d want %0d", i, m_data, i - 1); end
            checks++; if (count !== 3'd1) begin errors++; $display("[TB] FAIL b2b_count_%0d got %0d want 1", i, count); end
         end
         tick();
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("[TB] FAIL b2b_empty got %0b want 1", empty); end
      checks++; if (acc !== 12'd15) begin errors++; $display("[TB] FAIL b2b_acc got %0d want 15", acc); end
      m_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_clr();
      m_ready = 1'b0;
      applyStimulus(1'b1, 4'd1, 4'd2);
      tick();
      applyStimulus(1'b1, 4'd2, 4'd2);
      tick();
      applyStimulus(1'b1, 4'd5, 4'd0);
      tick();
      applyStimulus(1'b1, 4'd6, 4'd6);
      tick();
      // three entries held, fourth sample presented, op_valid still high
      applyStimulus(1'b1, 4'd7, 4'd7);
      #1;
      checks++; if (count !== 3'd3) begin errors++; $display("[TB] FAIL rmid_pre_count got %0d want 3", count); end
      checks++; if (acc !== 12'd12) begin errors++; $display("[TB] FAIL rmid_pre_acc got %0d want 12", acc); end
      arst = 1'b1;
      tick();
      arst = 1'b0;
      applyStimulus(1'b0, 4'd0, 4'd0);
      #1;
      checks++; if (count !== 3'd0) begin errors++; $display("[TB] FAIL rmid_count got %0d want 0", count); end
      checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_valid got %0b want 0", m_valid); end
      checks++; if (acc !== 12'd0) begin errors++; $display("[TB] FAIL rmid_acc got %0d want 0", acc); end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_late_valid_%0d got %0b want 0", i, m_valid); end
      end
      checks++; if (acc !== 12'd0) begin errors++; $display("[TB] FAIL rmid_late_acc got %0d want 0", acc); end
   endtask

   initial begin
      arst     = 1'b1;
      op_valid = 1'b0;
      a        = 4'd0;
      b        = 4'd0;
      clr      = 1'b0;
      m_ready  = 1'b0;
      tick();
      tick();
      test_reset();
      test_single_op();
      test_burst();
      test_overflow();
      test_full_pop_push();
      test_saturation_clr();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
